// File: rtl/tile_engine_if.sv
// Host-side bus of tile_engine: game controls, note-map write port and game status.
interface tile_engine_if #(
  parameter int LANES     = 4,
  parameter int ROWS      = 8,
  parameter int MAP_DEPTH = 16,
  parameter int FRAME_W   = 8,
  parameter int SCORE_W   = 17
);
  localparam int LANE_W  = $clog2(LANES);
  localparam int ADDR_W  = $clog2(MAP_DEPTH);
  localparam int ENTRY_W = LANE_W + 4 + FRAME_W;

  logic                     tick;
  logic                     start;
  logic [LANES-1:0]         keys;
  logic                     map_we;
  logic [ADDR_W-1:0]        map_addr;
  logic [ENTRY_W-1:0]       map_wdata;
  logic [ADDR_W:0]          map_count;
  logic [LANES*ROWS-1:0]    state_flat;
  logic [SCORE_W-1:0]       score;
  logic [7:0]               miss_count;
  logic [FRAME_W-1:0]       frame;
  logic                     busy;
  logic                     done;
  logic                     tick_overrun;

  modport master (
    output tick, start, keys, map_we, map_addr, map_wdata, map_count,
    input  state_flat, score, miss_count, frame, busy, done, tick_overrun
  );

  modport slave (
    input  tick, start, keys, map_we, map_addr, map_wdata, map_count,
    output state_flat, score, miss_count, frame, busy, done, tick_overrun
  );
endinterface

// File: rtl/tile_engine.sv
// Falling-tile game core: note-map scan, tile matrix scroll and key scoring.
// Optional build macro MISS_PENALTY_EN: misses and wrong presses also cost POINTS.
//
// state  | meaning
// IDLE   | after reset, waiting for start; map writable
// RUN    | game running, waiting for tick
// SCAN   | walking note map for entries due this frame
// COMMIT | shift matrix, spawn row 0, score outgoing bottom row
// DONE   | map exhausted and matrix empty; map writable
module tile_engine #(
  parameter int LANES     = 4,
  parameter int ROWS      = 8,
  parameter int MAP_DEPTH = 16,
  parameter int FRAME_W   = 8,
  parameter int SCORE_W   = 17,
  parameter int POINTS    = 10,
  parameter int SCORE_MAX = 9990
) (
  input logic          CLOCK_50,
  input logic          reset,
  tile_engine_if.slave bus
);
  localparam int LANE_W  = $clog2(LANES);
  localparam int ADDR_W  = $clog2(MAP_DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = LANE_W + 4 + FRAME_W;
  localparam int CELLS   = LANES * ROWS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [ENTRY_W-1:0]       map_mem [MAP_DEPTH];
  logic [2:0]               state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d, count_q, count_d;
  logic [FRAME_W-1:0]       frame_q, frame_d;
  logic [CELLS-1:0]         matrix_q, matrix_d;
  logic [LANES-1:0][3:0]    remaining_q, remaining_d;
  logic [LANES-1:0]         hit_q, hit_d, keys_q;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic [7:0]               miss_q, miss_d;
  logic                     overrun_q, overrun_d;

  logic [ENTRY_W-1:0]       entry;
  logic [FRAME_W-1:0]       e_start;
  logic [3:0]               e_len;
  logic [LANE_W-1:0]        e_lane;
  logic [LANES-1:0]         rise, bottom, wrong, good, hit_eff, new_row;
  logic                     in_game, commit;
  int                       n_wrong, n_hit, n_lost, score_sum, miss_sum;

  assign entry   = map_mem[ptr_q[ADDR_W-1:0]];
  assign e_start = entry[FRAME_W-1:0];
  assign e_len   = entry[FRAME_W +: 4];
  assign e_lane  = entry[FRAME_W+4 +: LANE_W];

  assign in_game = (state_q == S_RUN) || (state_q == S_SCAN) || (state_q == S_COMMIT);
  assign commit  = (state_q == S_COMMIT);
  assign rise    = bus.keys & ~keys_q;
  assign bottom  = matrix_q[CELLS-1 -: LANES];
  assign wrong   = in_game ? (rise & ~bottom) : '0;
  assign good    = in_game ? (rise & bottom) : '0;
  // an edge landing in the COMMIT cycle still counts against the outgoing row
  assign hit_eff = hit_q | good;

  always_comb begin
    for (int l = 0; l < LANES; l++) new_row[l] = (remaining_q[l] != 4'd0);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    frame_d     = frame_q;
    matrix_d    = matrix_q;
    remaining_d = remaining_q;
    hit_d       = hit_eff;
    overrun_d   = overrun_q;

    n_wrong   = $countones(wrong);
    n_hit     = commit ? $countones(bottom & hit_eff) : 0;
    n_lost    = commit ? $countones(bottom & ~hit_eff) : 0;
    miss_sum  = int'(miss_q) + n_wrong + n_lost;
    score_sum = int'(score_q) + POINTS * n_hit;
`ifdef MISS_PENALTY_EN
    score_sum = score_sum - POINTS * (n_wrong + n_lost);
`endif
    if (score_sum > SCORE_MAX) score_sum = SCORE_MAX;
    else if (score_sum < 0) score_sum = 0;
    score_d = SCORE_W'(score_sum);
    miss_d  = (miss_sum > 255) ? 8'd255 : 8'(miss_sum);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          ptr_d       = '0;
          count_d     = (bus.map_count > PTR_W'(MAP_DEPTH)) ? PTR_W'(MAP_DEPTH) : bus.map_count;
          frame_d     = '0;
          matrix_d    = '0;
          remaining_d = '0;
          hit_d       = '0;
          score_d     = '0;
          miss_d      = '0;
          overrun_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.tick) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (bus.tick) overrun_d = 1'b1;
        if (ptr_q == count_q) begin
          state_d = S_COMMIT;
        end else if (e_start == frame_q) begin
          remaining_d[e_lane] = e_len;
          ptr_d = ptr_q + 1'b1;
        end else if (e_start < frame_q) begin
          ptr_d = ptr_q + 1'b1;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (bus.tick) overrun_d = 1'b1;
        matrix_d = {matrix_q[CELLS-LANES-1:0], new_row};
        for (int l = 0; l < LANES; l++)
          if (remaining_q[l] != 4'd0) remaining_d[l] = remaining_q[l] - 4'd1;
        frame_d = frame_q + 1'b1;
        hit_d   = '0;
        if ((ptr_q == count_q) && (remaining_d == '0) && (matrix_d == '0))
          state_d = S_DONE;
        else
          state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      frame_q     <= '0;
      matrix_q    <= '0;
      remaining_q <= '0;
      hit_q       <= '0;
      keys_q      <= '0;
      score_q     <= '0;
      miss_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      matrix_q    <= matrix_d;
      remaining_q <= remaining_d;
      hit_q       <= hit_d;
      keys_q      <= bus.keys;
      score_q     <= score_d;
      miss_q      <= miss_d;
      overrun_q   <= overrun_d;
    end
  end

  // map contents survive reset so a restart replays the same song
  always_ff @(posedge CLOCK_50) begin
    if (bus.map_we && ((state_q == S_IDLE) || (state_q == S_DONE)))
      map_mem[bus.map_addr] <= bus.map_wdata;
  end

  assign bus.state_flat   = matrix_q;
  assign bus.score        = score_q;
  assign bus.miss_count   = miss_q;
  assign bus.frame        = frame_q;
  assign bus.busy         = (state_q == S_SCAN) || (state_q == S_COMMIT);
  assign bus.done         = (state_q == S_DONE);
  assign bus.tick_overrun = overrun_q;
endmodule

// File: tb/tb_tile_engine.sv
// Directed bench for tile_engine: scroll, scoring, latency, overrun, saturation, reset.
module tb_tile_engine;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   n;

  tile_engine_if bus ();

  tile_engine #(.SCORE_MAX(45)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic map_write(input int addr, input int lane, input int len, input int st);
    bus.map_we    = 1'b1;
    bus.map_addr  = 4'(addr);
    bus.map_wdata = {2'(lane), 4'(len), 8'(st)};
    @(negedge clk);
    bus.map_we    = 1'b0;
  endtask

  task automatic start_game(input int cnt);
    bus.map_count = 5'(cnt);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle_run();
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("tick_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    wait_idle_run();
  endtask

  task automatic press(input logic [3:0] mask);
    bus.keys = mask;
    @(negedge clk);
    bus.keys = 4'b0000;
  endtask

  // single-entry-scan frames: SCAN for one cycle, key edge lands in COMMIT
  task automatic tick_press_commit(input logic [3:0] mask);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    bus.keys = mask;
    @(negedge clk);
    bus.keys = 4'b0000;
    wait_idle_run();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.start     = 1'b0;
    bus.keys      = 4'b0000;
    bus.map_we    = 1'b0;
    bus.map_addr  = '0;
    bus.map_wdata = '0;
    bus.map_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state_flat", bus.state_flat, 32'h0);
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_miss", 32'(bus.miss_count), 32'd0);
    check("rst_frame", 32'(bus.frame), 32'd0);
    check("rst_flags", {29'd0, bus.busy, bus.done, bus.tick_overrun}, 32'd0);

    // scroll with no keys
    map_write(0, 0, 4, 0);
    map_write(1, 1, 4, 4);
    map_write(2, 2, 4, 8);
    map_write(3, 3, 4, 12);
    start_game(4);
    check("t1_frame0", 32'(bus.frame), 32'd0);
    repeat (4) do_tick();
    check("t1_tick4_matrix", bus.state_flat, 32'h0000_1111);
    check("t1_tick4_frame", 32'(bus.frame), 32'd4);
    repeat (4) do_tick();
    check("t1_tick8_matrix", bus.state_flat, 32'h1111_2222);
    check("t1_tick8_miss", 32'(bus.miss_count), 32'd0);
    do_tick();
    check("t1_tick9_matrix", bus.state_flat, 32'h1112_2224);
    check("t1_tick9_miss", 32'(bus.miss_count), 32'd1);
    check("t1_tick9_score", 32'(bus.score), 32'd0);

    // hits on lane0, repeat edge, start ignored mid-game, wrong press, run to DONE
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start_game(4);
    repeat (8) do_tick();
    press(4'b0001);
    @(negedge clk);
    press(4'b0001);
    check("t2_repeat_miss", 32'(bus.miss_count), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t2_start_ignored", 32'(bus.frame), 32'd8);
    do_tick();
    press(4'b0001);
    do_tick();
    press(4'b0001);
    do_tick();
    press(4'b0001);
    do_tick();
    check("t2_score40", 32'(bus.score), 32'd40);
    check("t2_miss0", 32'(bus.miss_count), 32'd0);
    press(4'b0100);
    check("t2_wrong_press", 32'(bus.miss_count), 32'd1);
    repeat (11) do_tick();
    check("t2_not_done", {31'd0, bus.done}, 32'd0);
    do_tick();
    check("t2_done", {31'd0, bus.done}, 32'd1);
    check("t2_final_miss", 32'(bus.miss_count), 32'd13);
    check("t2_final_frame", 32'(bus.frame), 32'd24);
    check("t2_final_score", 32'(bus.score), 32'd40);

    // saturation at SCORE_MAX, last hit pressed in the COMMIT cycle
    map_write(0, 0, 5, 0);
    start_game(1);
    check("t5_restart", {bus.score, bus.miss_count, 7'd0}, 32'd0);
    check("t5_not_done", {31'd0, bus.done}, 32'd0);
    repeat (8) do_tick();
    for (int i = 0; i < 4; i++) begin
      press(4'b0001);
      do_tick();
    end
    check("t5_score40", 32'(bus.score), 32'd40);
    tick_press_commit(4'b0001);
    check("t5_score_sat", 32'(bus.score), 32'd45);
    check("t5_miss", 32'(bus.miss_count), 32'd0);
    check("t5_done", {31'd0, bus.done}, 32'd1);

    // two entries in one frame: busy length and spawned row
    map_write(0, 0, 1, 0);
    map_write(1, 2, 1, 0);
    start_game(2);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t3_busy_cycles", 32'(n), 32'd4);
    check("t3_row0", bus.state_flat, 32'h0000_0005);

    // tick held into SCAN
    bus.tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.tick = 1'b0;
    wait_idle_run();
    repeat (2) @(negedge clk);
    check("t4_overrun", {31'd0, bus.tick_overrun}, 32'd1);
    check("t4_frame", 32'(bus.frame), 32'd2);
    check("t4_matrix", bus.state_flat, 32'h0000_0050);

    // map write ignored in RUN, reset mid-SCAN, replay
    map_write(1, 1, 1, 0);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("t6_in_scan", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_matrix", bus.state_flat, 32'h0);
    check("t6_rst_counts", {bus.score, bus.miss_count, bus.frame[6:0]}, 32'd0);
    check("t6_rst_flags", {29'd0, bus.busy, bus.done, bus.tick_overrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    start_game(2);
    do_tick();
    check("t6_replay_row0", bus.state_flat, 32'h0000_0005);
    check("t6_replay_frame", 32'(bus.frame), 32'd1);
    check("t6_overrun_clear", {31'd0, bus.tick_overrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
